regfile_wb_arbiter: RTL

- Shares the register file's single write port (WriteRg/WriteData/RegWrite) between two writeback requesters.
  - Source 0: main pipeline writeback.
  - Source 1: multicycle unit (mul/div, load).
- Fixed priority to source 0, with a starvation guard that forces a source-1 grant.
- Outputs are registered on posedge Clock, so the register file commits the write on the following negedge of the same cycle.

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_starve_counter.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths, the zero-register index and the arbiter state encoding.
package regfile_wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int ZERO_RG   = 0;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCED = 1'b1
    } wb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Starvation counter for the writeback arbiter's low-priority source.
// Ports: Clock, Reset (sync, active-low), i_live1, i_grant1 -> o_force.
module wb_starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_live1,
    input  logic i_grant1,
    output logic o_force
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;

    assign w_inc   = i_live1 && !i_grant1;
    // The denial that would reach the limit requests a forced grant instead.
    assign o_force = w_inc && (r_cnt == LAST);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (o_force || !w_inc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between two sources.
// Ports: Src0*/Src1* request+Ready, RegWrite/WriteRg/WriteData to the RF, Forced.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Src0Valid,
    input  logic [ADDR_W-1:0] Src0Rg,
    input  logic [DATA_W-1:0] Src0Data,
    output logic              Src0Ready,
    input  logic              Src1Valid,
    input  logic [ADDR_W-1:0] Src1Rg,
    input  logic [DATA_W-1:0] Src1Data,
    output logic              Src1Ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRg,
    output logic [DATA_W-1:0] WriteData,
    output logic              Forced
);

    localparam logic [ADDR_W-1:0] ZRG = ADDR_W'(ZERO_RG);

    wb_state_t         r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_rg;
    logic [DATA_W-1:0] r_data;

    logic w_zero0;
    logic w_zero1;
    logic w_live0;
    logic w_live1;
    logic w_grant0;
    logic w_grant1;
    logic w_force;

    assign w_zero0 = Src0Valid && (Src0Rg == ZRG);
    assign w_zero1 = Src1Valid && (Src1Rg == ZRG);
    assign w_live0 = Src0Valid && (Src0Rg != ZRG);
    assign w_live1 = Src1Valid && (Src1Rg != ZRG);

    // FORCED flips the priority for exactly one cycle.
    assign w_grant1 = Reset && ((r_state == FORCED) ? w_live1
                                                    : (w_live1 && !w_live0));
    assign w_grant0 = Reset && w_live0 && !w_grant1;

    // Zero-register writes are absorbed without taking the write slot.
    assign Src0Ready = Reset && (w_zero0 || w_grant0);
    assign Src1Ready = Reset && (w_zero1 || w_grant1);

    wb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .Clock    (Clock),
        .Reset    (Reset),
        .i_live1  (w_live1),
        .i_grant1 (w_grant1),
        .o_force  (w_force)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= NORMAL;
            r_we    <= 1'b0;
            r_rg    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_force ? FORCED : NORMAL;
            r_we    <= w_grant0 || w_grant1;
            if (w_grant1) begin
                r_rg   <= Src1Rg;
                r_data <= Src1Data;
            end else if (w_grant0) begin
                r_rg   <= Src0Rg;
                r_data <= Src0Data;
            end
        end
    end

    assign RegWrite  = r_we;
    assign WriteRg   = r_rg;
    assign WriteData = r_data;
    assign Forced    = (r_state == FORCED);

endmodule
